id_ex_operand_stage: RTL

ID/EX pipeline stage that registers decoded instructions and delivers `op1`, `op2` and `operand` directly to the 64-bit main ALU. It resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages, and refreshes held operands while stalled. It presents a one-entry valid/ready buffer with flush.

---
 rtl/id_ex_operand_stage.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: one-entry valid/ready buffer that delivers op1/op2/operand to the main ALU.
// FORWARD_EN selects EX/MEM + MEM/WB forwarding with stall refresh; otherwise RAW hazards hold off in_ready.
module id_ex_operand_stage #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [RIDX_W-1:0] in_rs1_idx,
    input  logic [RIDX_W-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic              in_use_pc,
    input  logic              in_use_imm,
    input  logic [2:0]        in_aluop,
    input  logic [RIDX_W-1:0] in_rd_idx,
    input  logic              in_rd_we,
    input  logic              flush,
    input  logic [RIDX_W-1:0] exmem_rd_idx,
    input  logic [RIDX_W-1:0] memwb_rd_idx,
    input  logic              exmem_rd_we,
    input  logic              memwb_rd_we,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [XLEN-1:0]   memwb_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   op1,
    output logic [XLEN-1:0]   op2,
    output logic [2:0]        operand,
    output logic [XLEN-1:0]   out_store_data,
    output logic [XLEN-1:0]   out_pc,
    output logic [RIDX_W-1:0] out_rd_idx,
    output logic              out_rd_we
);

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [RIDX_W-1:0] r_rs1_idx;
    logic [RIDX_W-1:0] r_rs2_idx;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic              r_use_pc;
    logic              r_use_imm;
    logic [2:0]        r_aluop;
    logic [RIDX_W-1:0] r_rd_idx;
    logic              r_rd_we;

    logic              w_in1_ex;
    logic              w_in1_mw;
    logic              w_in2_ex;
    logic              w_in2_mw;
    logic              w_hazard;
    logic              w_load;
    logic              w_hold;
    logic [XLEN-1:0]   w_cap_rs1;
    logic [XLEN-1:0]   w_cap_rs2;
    logic [XLEN-1:0]   w_rs1_fwd;
    logic [XLEN-1:0]   w_rs2_fwd;

    function automatic logic f_match(input logic [RIDX_W-1:0] src,
                                     input logic [RIDX_W-1:0] dst,
                                     input logic              we);
        return (src != '0) && we && (dst == src);
    endfunction

    assign w_in1_ex = f_match(in_rs1_idx, exmem_rd_idx, exmem_rd_we);
    assign w_in1_mw = f_match(in_rs1_idx, memwb_rd_idx, memwb_rd_we);
    assign w_in2_ex = f_match(in_rs2_idx, exmem_rd_idx, exmem_rd_we);
    assign w_in2_mw = f_match(in_rs2_idx, memwb_rd_idx, memwb_rd_we);

`ifdef FORWARD_EN
    logic w_h1_ex;
    logic w_h1_mw;
    logic w_h2_ex;
    logic w_h2_mw;

    assign w_h1_ex = f_match(r_rs1_idx, exmem_rd_idx, exmem_rd_we);
    assign w_h1_mw = f_match(r_rs1_idx, memwb_rd_idx, memwb_rd_we);
    assign w_h2_ex = f_match(r_rs2_idx, exmem_rd_idx, exmem_rd_we);
    assign w_h2_mw = f_match(r_rs2_idx, memwb_rd_idx, memwb_rd_we);

    // Same EX/MEM > MEM/WB > regfile priority at capture and on the held copy.
    always_comb begin
        w_cap_rs1 = in_rs1_data;
        if (in_rs1_idx == '0)  w_cap_rs1 = '0;
        else if (w_in1_ex)     w_cap_rs1 = exmem_result;
        else if (w_in1_mw)     w_cap_rs1 = memwb_result;

        w_cap_rs2 = in_rs2_data;
        if (in_rs2_idx == '0)  w_cap_rs2 = '0;
        else if (w_in2_ex)     w_cap_rs2 = exmem_result;
        else if (w_in2_mw)     w_cap_rs2 = memwb_result;

        w_rs1_fwd = r_rs1_data;
        if (w_h1_ex)           w_rs1_fwd = exmem_result;
        else if (w_h1_mw)      w_rs1_fwd = memwb_result;

        w_rs2_fwd = r_rs2_data;
        if (w_h2_ex)           w_rs2_fwd = exmem_result;
        else if (w_h2_mw)      w_rs2_fwd = memwb_result;
    end

    assign w_hazard = 1'b0;
`else
    logic w_unused_nofwd;

    always_comb begin
        w_cap_rs1 = (in_rs1_idx == '0) ? '0 : in_rs1_data;
        w_cap_rs2 = (in_rs2_idx == '0) ? '0 : in_rs2_data;
        w_rs1_fwd = r_rs1_data;
        w_rs2_fwd = r_rs2_data;
    end

    // rs2 always feeds store data, so it counts as used even when op2 takes the immediate.
    assign w_hazard = (!in_use_pc && (w_in1_ex || w_in1_mw)) || w_in2_ex || w_in2_mw;

    assign w_unused_nofwd = ^{exmem_result, memwb_result, r_rs1_idx, r_rs2_idx};
`endif

    assign in_ready = (!r_valid || out_ready) && !w_hazard;
    assign w_load   = in_valid && in_ready && !flush;
    assign w_hold   = r_valid && !out_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_rs1_idx  <= '0;
            r_rs2_idx  <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_use_pc   <= 1'b0;
            r_use_imm  <= 1'b0;
            r_aluop    <= '0;
            r_rd_idx   <= '0;
            r_rd_we    <= 1'b0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_rd_we    <= 1'b0;
        end else if (w_load) begin
            r_valid    <= 1'b1;
            r_pc       <= in_pc;
            r_rs1_idx  <= in_rs1_idx;
            r_rs2_idx  <= in_rs2_idx;
            r_rs1_data <= w_cap_rs1;
            r_rs2_data <= w_cap_rs2;
            r_imm      <= in_imm;
            r_use_pc   <= in_use_pc;
            r_use_imm  <= in_use_imm;
            r_aluop    <= in_aluop;
            r_rd_idx   <= in_rd_idx;
            r_rd_we    <= in_rd_we;
        end else if (r_valid && out_ready) begin
            r_valid    <= 1'b0;
        end else if (w_hold) begin
            // Latch whatever is being forwarded so a value retiring past MEM/WB survives the stall.
            r_rs1_data <= w_rs1_fwd;
            r_rs2_data <= w_rs2_fwd;
        end
    end

    assign out_valid      = r_valid;
    assign op1            = r_use_pc  ? r_pc  : w_rs1_fwd;
    assign op2            = r_use_imm ? r_imm : w_rs2_fwd;
    assign operand        = r_aluop;
    assign out_store_data = w_rs2_fwd;
    assign out_pc         = r_pc;
    assign out_rd_idx     = r_rd_idx;
    assign out_rd_we      = r_rd_we;

endmodule
